// File: rtl/load_sequencer.sv
// Round-robin load sequencer: grants one requester, latches its word and frames a
// permit pulse with setup/hold margins. Optional readback check: LOAD_SEQUENCER_READBACK_EN.
module load_sequencer #(
  parameter int NREQ         = 2,
  parameter int WIDTH        = 16,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] data_i,
`ifdef LOAD_SEQUENCER_READBACK_EN
  input  logic [WIDTH-1:0]      rdback_i,
  output logic                  rb_err_o,
`endif
  output logic [NREQ-1:0]       ack_o,
  output logic                  permit_o,
  output logic [WIDTH-1:0]      values_o,
  output logic                  busy_o,
  output logic [IDW-1:0]        grant_id_o
);

  localparam int MAXSP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAXC  = (MAXSP > HOLD_CYCLES) ? MAXSP : HOLD_CYCLES;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, ACK} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [IDW-1:0]    grant_q, grant_d;
  logic [WIDTH-1:0]  values_q, values_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              permit_q, permit_d;
  logic              busy_q, busy_d;
  logic              win_found_s;
  logic [IDW-1:0]    win_idx_s;
`ifdef LOAD_SEQUENCER_READBACK_EN
  logic              rb_err_q, rb_err_d;
`endif

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = (int'(base) + off) % NREQ;
    return IDW'(sum);
  endfunction

  // Scan downward so the candidate closest to the rr pointer is the last one written.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[wrap_idx(rr_q, k)]) begin
        win_found_s = 1'b1;
        win_idx_s   = wrap_idx(rr_q, k);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    values_d = values_q;
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          values_d = data_i[win_idx_s*WIDTH +: WIDTH];
          grant_d  = win_idx_s;
          cnt_d    = CW'(SETUP_CYCLES - 1);
          state_d  = SETUP;
        end else begin
          state_d  = IDLE;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(PULSE_CYCLES - 1);
          state_d = PULSE;
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(HOLD_CYCLES - 1);
          state_d = HOLD;
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
      end
      ACK: begin
        rr_d    = wrap_idx(grant_q, 1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs decode the next state so they are registered yet aligned with it.
    permit_d = (state_d == PULSE);
    busy_d   = (state_d != IDLE);
    ack_d    = (state_d == ACK) ? (NREQ'(1) << grant_d) : '0;
`ifdef LOAD_SEQUENCER_READBACK_EN
    rb_err_d = rb_err_q | ((state_q == ACK) && (rdback_i != values_q));
`endif
  end

  // State and output registers; reset aborts any transaction without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_q     <= '0;
      grant_q  <= '0;
      values_q <= '0;
      ack_q    <= '0;
      permit_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef LOAD_SEQUENCER_READBACK_EN
      rb_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      values_q <= values_d;
      ack_q    <= ack_d;
      permit_q <= permit_d;
      busy_q   <= busy_d;
`ifdef LOAD_SEQUENCER_READBACK_EN
      rb_err_q <= rb_err_d;
`endif
    end
  end

  assign ack_o      = ack_q;
  assign permit_o   = permit_q;
  assign values_o   = values_q;
  assign busy_o     = busy_q;
  assign grant_id_o = grant_q;
`ifdef LOAD_SEQUENCER_READBACK_EN
  assign rb_err_o   = rb_err_q;
`endif

endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench for load_sequencer: vector table of transactions plus a mid-pulse reset
// sequence; readback checks compile in with LOAD_SEQUENCER_READBACK_EN.
module tb_load_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req;
  logic [31:0] data;
  logic [1:0]  ack;
  logic        permit;
  logic [15:0] values;
  logic        busy;
  logic [0:0]  grant_id;
`ifdef LOAD_SEQUENCER_READBACK_EN
  logic [15:0] rdback;
  logic        rb_err;
`endif
  logic        exp_rb_err;

  int n_tests = 0;
  int n_fail  = 0;

  load_sequencer #(
    .NREQ(2), .WIDTH(16), .SETUP_CYCLES(1), .PULSE_CYCLES(2), .HOLD_CYCLES(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .data_i     (data),
`ifdef LOAD_SEQUENCER_READBACK_EN
    .rdback_i   (rdback),
    .rb_err_o   (rb_err),
`endif
    .ack_o      (ack),
    .permit_o   (permit),
    .values_o   (values),
    .busy_o     (busy),
    .grant_id_o (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [15:0] d0;
    logic [15:0] d1;
    int          drop_k;
    logic        chg;
    logic [15:0] chg_val;
    logic        rb_flip;
    logic [0:0]  exp_gid;
    logic [15:0] exp_val;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called on a negedge; walks the transaction cycle by cycle from the first busy cycle.
  task automatic run_vec(input vec_t v, input int idx);
    bit started;
    started = 1'b0;
    req  = v.req;
    data = {v.d1, v.d0};
`ifdef LOAD_SEQUENCER_READBACK_EN
    rdback = v.exp_val ^ {15'd0, v.rb_flip};
`endif
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      if (busy) begin
        started = 1'b1;
        break;
      end
    end
    chk($sformatf("v%0d start", idx), {31'd0, started}, 32'd1);
    if (!started) return;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("v%0d k%0d busy", idx, k), {31'd0, busy}, {31'd0, (k <= 5)});
      chk($sformatf("v%0d k%0d permit", idx, k), {31'd0, permit}, {31'd0, (k == 2 || k == 3)});
      chk($sformatf("v%0d k%0d ack", idx, k), {30'd0, ack},
          (k == 5) ? ((v.exp_gid == 1'b1) ? 32'd2 : 32'd1) : 32'd0);
      if (k <= 5) chk($sformatf("v%0d k%0d values", idx, k), {16'd0, values}, {16'd0, v.exp_val});
      if (k == 5) chk($sformatf("v%0d grant_id", idx), {31'd0, grant_id}, {31'd0, v.exp_gid});
`ifdef LOAD_SEQUENCER_READBACK_EN
      if (k == 6) begin
        if (v.rb_flip) exp_rb_err = 1'b1;
        chk($sformatf("v%0d rb_err", idx), {31'd0, rb_err}, {31'd0, exp_rb_err});
      end
`endif
      if (v.chg && k == 2) data[15:0] = v.chg_val;
      if (k == v.drop_k) req = 2'b00;
    end
  endtask

  initial begin
    bit seen;
    //          req    d0        d1        drop chg   chg_val  flip  gid   val
    vecs[0]  = '{2'b01, 16'hA5C3, 16'h0000, 5, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hA5C3};
    vecs[1]  = '{2'b10, 16'h0000, 16'hBEEF, 5, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
    vecs[2]  = '{2'b11, 16'h1111, 16'h2222, 5, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1111};
    vecs[3]  = '{2'b11, 16'h1111, 16'h2222, 5, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h2222};
    vecs[4]  = '{2'b11, 16'h1111, 16'h2222, 5, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1111};
    vecs[5]  = '{2'b11, 16'h1111, 16'h2222, 5, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h2222};
    vecs[6]  = '{2'b01, 16'h00FF, 16'h0000, 5, 1'b1, 16'hFF00, 1'b0, 1'b0, 16'h00FF};
    vecs[7]  = '{2'b01, 16'h1357, 16'h0000, 1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1357};
    vecs[8]  = '{2'b01, 16'hCAFE, 16'h0000, 5, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hCAFE};
    vecs[9]  = '{2'b01, 16'h0F0F, 16'h0000, 5, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0F0F};
    vecs[10] = '{2'b11, 16'h7777, 16'h8888, 5, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h7777};

    req = 2'b00;
    data = 32'd0;
    exp_rb_err = 1'b0;
`ifdef LOAD_SEQUENCER_READBACK_EN
    rdback = 16'd0;
`endif
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset permit", {31'd0, permit}, 32'd0);
    chk("reset values", {16'd0, values}, 32'd0);
    chk("reset ack", {30'd0, ack}, 32'd0);
    chk("reset grant_id", {31'd0, grant_id}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Abort a transaction while permit is high.
    req  = 2'b10;
    data = {16'h5A5A, 16'h0000};
    seen = 1'b0;
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      if (permit) begin
        seen = 1'b1;
        break;
      end
    end
    chk("midreset permit seen", {31'd0, seen}, 32'd1);
    rst_n = 1'b0;
    #1;
    exp_rb_err = 1'b0;
    chk("midreset permit", {31'd0, permit}, 32'd0);
    chk("midreset values", {16'd0, values}, 32'd0);
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset ack", {30'd0, ack}, 32'd0);
`ifdef LOAD_SEQUENCER_READBACK_EN
    chk("midreset rb_err", {31'd0, rb_err}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    req   = 2'b00;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("post-reset c%0d ack", c), {30'd0, ack}, 32'd0);
      chk($sformatf("post-reset c%0d busy", c), {31'd0, busy}, 32'd0);
    end

    run_vec(vecs[10], 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_sequencer.md
Name: load_sequencer

Overview:
- Controller and arbiter for the 16-bit loader datapath.
- Several requesters each want to write a 16-bit word into the flip-flop register that the loader drives.
- The block arbitrates round-robin, latches the winning word and presents it on values.
- It frames a permit pulse with setup and hold margins, then acknowledges the winner.
- It sits between the requesting units and the loader's permit/values inputs.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WIDTH, 16, loaded word width; matches the loader values bus.
- SETUP_CYCLES, 1, cycles values are stable before permit rises (>=1).
- PULSE_CYCLES, 2, cycles permit stays high (>=1).
- HOLD_CYCLES, 1, cycles values stay stable after permit falls (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  NREQ  per-requester load request, level.
- data  in  NREQ*WIDTH  requester words; requester i owns bits [i*WIDTH +: WIDTH].
- ack  out  NREQ  one-cycle completion pulse to the granted requester.
- permit  out  1  to the loader permit input.
- values  out  WIDTH  to the loader values input.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  clog2(NREQ) (min 1)  index of the current or last granted requester.

Behaviour:
- Reset: while rst_n=0, force state=IDLE, permit=0, values=0, ack=0, busy=0, grant_id=0, rr pointer=0, counter=0.
  - Reset acts immediately, even mid-transaction. The aborted requester gets no ack and must re-request.
- Every output is driven from a register; there are no combinational paths from input to output.
- FSM states: IDLE, SETUP, PULSE, HOLD, ACK.
- IDLE:
  - If any req bit is high at the clock edge, pick the winner: the first set bit scanning from the rr pointer upward, wrapping modulo NREQ.
  - On that edge, latch the winner's data slice into values and the winner's index into grant_id. Load the counter with SETUP_CYCLES-1 and go to SETUP.
  - Otherwise stay in IDLE. values holds its last value; permit=0.
- SETUP: permit=0 and values stable. When counter=0, load PULSE_CYCLES-1 and go to PULSE; otherwise decrement.
- PULSE: permit=1. When counter=0, load HOLD_CYCLES-1 and go to HOLD.
- HOLD: permit=0 and values still stable. When counter=0, go to ACK.
- ACK:
  - ack[grant_id]=1 for exactly one cycle. Set the rr pointer to (grant_id+1) mod NREQ and return to IDLE.
  - IDLE can grant again on the very next edge, so back-to-back transactions have a 1-cycle IDLE gap.
- Latency: req sampled at edge t → values valid from t+1 → permit high for cycles t+1+S through t+S+P → ack high in cycle t+1+S+P+H. With defaults, ack is 5 cycles after the sampling edge.
- Handshake rules:
  - A requester holds req high until it sees ack, then drops req.
  - data is sampled only at grant; later changes to data are ignored.
  - If req drops mid-transaction, the load still completes and ack is still issued.
  - If req is still high in the IDLE cycle after ack, it is treated as a new request.
- Simultaneous requests are served round-robin; no requester waits more than NREQ transactions.
- values never changes while busy=1. permit is never high in IDLE, SETUP, HOLD or ACK.
- The counter is wide enough for max(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES)-1.

Optional Feature:
- Macro: LOAD_SEQUENCER_READBACK_EN.
- Defined: adds input rdback (WIDTH) and output rb_err (1, reset 0).
  - In ACK, compare rdback with values.
  - On mismatch, rb_err is set and is sticky until reset; ack is still issued.
- Undefined: neither port exists and no compare logic is built.

Test Plan:
- Single load: after reset, req=2'b01 with data0=16'hA5C3. Expect:
  - values=A5C3 one cycle after sampling;
  - permit high for exactly 2 cycles, starting 2 cycles after sampling;
  - ack=2'b01 for 1 cycle, 5 cycles after sampling;
  - busy high for 5 cycles.
- Contention: req=2'b11 held, data0=1111, data1=2222. Expect grants in the order 0,1,0,1 with grant_id matching; two acks per requester in 4 transactions.
- Data change after grant: data0 changes from 00FF to FF00 during PULSE. Expect values stays 00FF through HOLD.
- Reset mid-PULSE: assert rst_n=0 while permit=1. Expect permit=0, values=0 and busy=0 with no clock edge; no ack after release.
- Early req drop: req0 falls during SETUP. Expect the transaction completes and ack[0] still pulses once.
- Readback (macro defined): rdback=values^16'h0001 during ACK. Expect rb_err=1, sticky across later clean loads, cleared only by reset.
